// File: rtl/spm_ocp_burst_slave.sv
// OCP burst slave bridge in front of the byte-enabled scratchpad: sequences BURST_LEN-word
// read/write bursts onto the single-word SPM port. Define SPM_OCP_ERR_EN to answer reserved MCmd codes with ERR.
module spm_ocp_burst_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            io_ocp_MCmd,
    input  logic [ADDR_WIDTH-1:0] io_ocp_MAddr,
    input  logic [31:0]           io_ocp_MData,
    input  logic [3:0]            io_ocp_MDataByteEn,
    input  logic                  io_ocp_MDataValid,
    output logic                  io_ocp_SCmdAccept,
    output logic                  io_ocp_SDataAccept,
    output logic [1:0]            io_ocp_SResp,
    output logic [31:0]           io_ocp_SData,
    output logic [ADDR_WIDTH-1:0] io_spm_M_Addr,
    output logic [31:0]           io_spm_M_Data,
    output logic [3:0]            io_spm_M_ByteEn,
    output logic                  io_spm_M_We,
    input  logic [31:0]           io_spm_S_Data
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int OFF_W = CNT_W + 2;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            sresp_q, sresp_d;
    logic [31:0]           sdata_q, sdata_d;

    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  last_word;
    logic                  addr_unused;

    // Bursts always cover the aligned block, so the in-block offset bits of MAddr are dropped.
    assign cmd_base    = {io_ocp_MAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign addr_unused = ^io_ocp_MAddr[OFF_W-1:0];
    assign word_addr   = base_q + (ADDR_WIDTH'(cnt_q) << 2);
    assign last_word   = (cnt_q == CNT_W'(BURST_LEN - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch;
    // combinational blocks use blocking '=', the state register below uses non-blocking '<='.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        base_d             = base_q;
        sresp_d            = RESP_NULL;
        sdata_d            = sdata_q;
        io_ocp_SCmdAccept  = 1'b0;
        io_ocp_SDataAccept = 1'b0;
        io_spm_M_We        = 1'b0;
        io_spm_M_Addr      = '0;
        io_spm_M_Data      = '0;
        io_spm_M_ByteEn    = '0;

        unique case (state_q)
            ST_IDLE: begin
                io_ocp_SCmdAccept  = 1'b1;
                io_ocp_SDataAccept = 1'b1;
                case (io_ocp_MCmd)
                    CMD_IDLE: begin
                    end
                    CMD_RD: begin
                        base_d  = cmd_base;
                        cnt_d   = '0;
                        state_d = ST_RD;
                    end
                    CMD_WR: begin
                        base_d  = cmd_base;
                        state_d = ST_WR;
                        cnt_d   = '0;
                        // Word 0 normally rides along with the command and is written immediately.
                        if (io_ocp_MDataValid) begin
                            io_spm_M_We     = 1'b1;
                            io_spm_M_Addr   = cmd_base;
                            io_spm_M_Data   = io_ocp_MData;
                            io_spm_M_ByteEn = io_ocp_MDataByteEn;
                            cnt_d           = CNT_W'(1);
                        end
                    end
                    default: begin
`ifdef SPM_OCP_ERR_EN
                        sresp_d = RESP_ERR;
`endif
                    end
                endcase
            end
            ST_RD: begin
                io_spm_M_Addr = word_addr;
                sdata_d       = io_spm_S_Data;
                sresp_d       = RESP_DVA;
                cnt_d         = cnt_q + CNT_W'(1);
                if (last_word) state_d = ST_IDLE;
            end
            ST_WR: begin
                io_ocp_SDataAccept = 1'b1;
                io_spm_M_Addr      = word_addr;
                if (io_ocp_MDataValid) begin
                    io_spm_M_We     = 1'b1;
                    io_spm_M_Data   = io_ocp_MData;
                    io_spm_M_ByteEn = io_ocp_MDataByteEn;
                    cnt_d           = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        sresp_d = RESP_DVA;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A burst aborted by reset must not write in the reset cycle itself.
        if (reset) begin
            io_spm_M_We     = 1'b0;
            io_spm_M_Addr   = '0;
            io_spm_M_Data   = '0;
            io_spm_M_ByteEn = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            sresp_q <= RESP_NULL;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            sresp_q <= sresp_d;
            sdata_q <= sdata_d;
        end
    end

    assign io_ocp_SResp = sresp_q;
    assign io_ocp_SData = sdata_q;

endmodule
